// File: rtl/cv32e40s_sleep_clk_ctrl.sv
// WFI sleep sequencer: drains the core, gates its clock, restores it on wake.
// Optional macro CV32E40S_SLEEP_STATS_EN adds a saturating sleep cycle counter.
//   state | meaning
//   AWAKE | core clock running, no sleep in progress
//   DRAIN | sleep requested, waiting for core_busy_i low (bounded)
//   SLEEP | core clock gated off, waiting for wake_i
//   WAKE  | core clock restored, settling before wake_o
module cv32e40s_sleep_clk_ctrl #(
    parameter int unsigned DRAIN_TIMEOUT = 16,
    parameter int unsigned WAKE_SETTLE   = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        sleep_req_i,
    input  logic        core_busy_i,
    input  logic        wake_i,
    output logic        clk_en_o,
    output logic        core_sleep_o,
    output logic        wake_o,
    output logic        timeout_o
`ifdef CV32E40S_SLEEP_STATS_EN
    ,
    output logic [31:0] sleep_cycles_o
`endif
);

    localparam logic [1:0] AWAKE = 2'd0;
    localparam logic [1:0] DRAIN = 2'd1;
    localparam logic [1:0] SLEEP = 2'd2;
    localparam logic [1:0] WAKE  = 2'd3;

    localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_TIMEOUT - 1);
    localparam logic [7:0] WAKE_LAST  = 8'(WAKE_SETTLE - 1);

    if (DRAIN_TIMEOUT < 1 || DRAIN_TIMEOUT > 255) begin : g_bad_drain_timeout
        $error("DRAIN_TIMEOUT must be in 1..255");
    end
    if (WAKE_SETTLE < 1 || WAKE_SETTLE > 255) begin : g_bad_wake_settle
        $error("WAKE_SETTLE must be in 1..255");
    end

    logic [1:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       clk_en_q, clk_en_d;
    logic       core_sleep_q, core_sleep_d;
    logic       wake_q, wake_d;
    logic       timeout_q, timeout_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = 8'd0;
        wake_d    = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            AWAKE: begin
                if (sleep_req_i && !wake_i) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // wake beats a completed drain, which beats the timeout
                if (wake_i) begin
                    state_d = AWAKE;
                end else if (!core_busy_i) begin
                    state_d = SLEEP;
                end else if (cnt_q == DRAIN_LAST) begin
                    state_d   = AWAKE;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            SLEEP: begin
                if (wake_i) begin
                    state_d = WAKE;
                end
            end
            WAKE: begin
                if (cnt_q == WAKE_LAST) begin
                    state_d = AWAKE;
                    wake_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = AWAKE;
            end
        endcase
        clk_en_d     = (state_d != SLEEP);
        core_sleep_d = (state_d == SLEEP);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= AWAKE;
            cnt_q        <= 8'd0;
            clk_en_q     <= 1'b1;
            core_sleep_q <= 1'b0;
            wake_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            clk_en_q     <= clk_en_d;
            core_sleep_q <= core_sleep_d;
            wake_q       <= wake_d;
            timeout_q    <= timeout_d;
        end
    end

    assign clk_en_o     = clk_en_q;
    assign core_sleep_o = core_sleep_q;
    assign wake_o       = wake_q;
    assign timeout_o    = timeout_q;

`ifdef CV32E40S_SLEEP_STATS_EN
    logic [31:0] sleep_cycles_q, sleep_cycles_d;

    // counts edges that leave the FSM in SLEEP, so it tracks core_sleep_o high cycles
    always_comb begin
        sleep_cycles_d = sleep_cycles_q;
        if (state_d == SLEEP && sleep_cycles_q != 32'hFFFF_FFFF) begin
            sleep_cycles_d = sleep_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sleep_cycles_q <= 32'd0;
        end else begin
            sleep_cycles_q <= sleep_cycles_d;
        end
    end

    assign sleep_cycles_o = sleep_cycles_q;
`endif

endmodule

// File: tb/tb_cv32e40s_sleep_clk_ctrl.sv
// Scoreboard bench for cv32e40s_sleep_clk_ctrl: default instance plus a
// DRAIN_TIMEOUT=1 / WAKE_SETTLE=1 corner instance sharing the same inputs.
module tb_cv32e40s_sleep_clk_ctrl;

    logic clk = 1'b0;
    logic rst_i = 1'b1;
    logic sleep_req_i = 1'b0;
    logic core_busy_i = 1'b0;
    logic wake_i = 1'b0;

    logic ce0, sl0, wk0, to0;
    logic ce1, sl1, wk1, to1;
`ifdef CV32E40S_SLEEP_STATS_EN
    logic [31:0] st0, st1;
`endif

    always #5 clk = ~clk;

    cv32e40s_sleep_clk_ctrl u_dut0 (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .sleep_req_i  (sleep_req_i),
        .core_busy_i  (core_busy_i),
        .wake_i       (wake_i),
        .clk_en_o     (ce0),
        .core_sleep_o (sl0),
        .wake_o       (wk0),
        .timeout_o    (to0)
`ifdef CV32E40S_SLEEP_STATS_EN
        ,
        .sleep_cycles_o (st0)
`endif
    );

    cv32e40s_sleep_clk_ctrl #(
        .DRAIN_TIMEOUT (1),
        .WAKE_SETTLE   (1)
    ) u_dut1 (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .sleep_req_i  (sleep_req_i),
        .core_busy_i  (core_busy_i),
        .wake_i       (wake_i),
        .clk_en_o     (ce1),
        .core_sleep_o (sl1),
        .wake_o       (wk1),
        .timeout_o    (to1)
`ifdef CV32E40S_SLEEP_STATS_EN
        ,
        .sleep_cycles_o (st1)
`endif
    );

    // output vector order: {clk_en, core_sleep, wake, timeout}
    localparam logic [3:0] O_RUN   = 4'b1000;
    localparam logic [3:0] O_SLEEP = 4'b0100;
    localparam logic [3:0] O_WAKEP = 4'b1010;
    localparam logic [3:0] O_TOP   = 4'b1001;

    typedef struct {
        int          cyc;
        int          dut;
        logic [3:0]  o;
        bit          has_st;
        logic [31:0] st;
        string       name;
    } exp_t;

    exp_t sbq[$];
    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;
    logic [3:0] act;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_exp(input int k, input int d, input logic [3:0] o, input string nm);
        exp_t e;
        e.cyc = cyc + k; e.dut = d; e.o = o; e.has_st = 1'b0; e.st = 32'd0; e.name = nm;
        sbq.push_back(e);
    endtask

    task automatic push_exp_st(input int k, input logic [3:0] o, input logic [31:0] st,
                               input string nm);
        exp_t e;
        e.cyc = cyc + k; e.dut = 0; e.o = o; e.has_st = 1'b1; e.st = st; e.name = nm;
        sbq.push_back(e);
    endtask

    always @(negedge clk) begin
        for (int i = sbq.size() - 1; i >= 0; i--) begin
            if (sbq[i].cyc == cyc) begin
                act = (sbq[i].dut == 0) ? {ce0, sl0, wk0, to0} : {ce1, sl1, wk1, to1};
                n_tests++;
                if (act !== sbq[i].o) begin
                    n_fail++;
                    $display("FAIL %s dut%0d cyc %0d: got {ce,sl,wk,to}=%b want %b",
                             sbq[i].name, sbq[i].dut, cyc, act, sbq[i].o);
                end
`ifdef CV32E40S_SLEEP_STATS_EN
                if (sbq[i].has_st) begin
                    n_tests++;
                    if (st0 !== sbq[i].st) begin
                        n_fail++;
                        $display("FAIL %s_count cyc %0d: got %h want %h",
                                 sbq[i].name, cyc, st0, sbq[i].st);
                    end
                end
`endif
                sbq.delete(i);
            end
        end
    end

    initial begin
        // reset held for two edges
        push_exp(1, 0, O_RUN, "reset1");
        push_exp(2, 0, O_RUN, "reset2");
        push_exp(2, 1, O_RUN, "reset2_c");
        tick(2);
        rst_i = 1'b0;

        // normal sleep, then wake with sleep_req still high -> re-entry after wake_o
        sleep_req_i = 1'b1;
        push_exp(1, 0, O_RUN,   "drain");
        push_exp(2, 0, O_SLEEP, "sleep_entry");
        tick(2);
        for (int k = 1; k <= 3; k++) push_exp(k, 0, O_SLEEP, "sleep_hold");
        tick(3);
        wake_i = 1'b1;
        push_exp(1, 0, O_RUN,   "wake_clk_en");
        push_exp(2, 0, O_RUN,   "wake_settle");
        push_exp(3, 0, O_WAKEP, "wake_pulse");
        push_exp(4, 0, O_RUN,   "reentry_drain");
        push_exp(5, 0, O_SLEEP, "reentry_sleep");
        tick(1);
        wake_i = 1'b0;
        tick(4);
        sleep_req_i = 1'b0;
        wake_i = 1'b1;
        push_exp(1, 0, O_RUN,   "wake2_clk_en");
        push_exp(2, 0, O_RUN,   "wake2_settle");
        push_exp(3, 0, O_WAKEP, "wake2_pulse");
        push_exp(4, 0, O_RUN,   "wake2_pulse_once");
        tick(1);
        wake_i = 1'b0;
        tick(3);

        // drain timeout after 16 busy cycles, then re-entry on the following edge
        sleep_req_i = 1'b1;
        core_busy_i = 1'b1;
        for (int k = 1; k <= 16; k++) push_exp(k, 0, O_RUN, "drain_wait");
        push_exp(17, 0, O_TOP,   "timeout");
        push_exp(18, 0, O_RUN,   "timeout_reentry");
        push_exp(19, 0, O_SLEEP, "timeout_reentry_sleep");
        tick(17);
        core_busy_i = 1'b0;
        tick(2);
        sleep_req_i = 1'b0;
        wake_i = 1'b1;
        push_exp(1, 0, O_RUN,   "wake3_clk_en");
        push_exp(3, 0, O_WAKEP, "wake3_pulse");
        tick(1);
        wake_i = 1'b0;
        tick(3);

        // sleep_req and wake together in AWAKE: stay AWAKE
        sleep_req_i = 1'b1;
        wake_i = 1'b1;
        push_exp(1, 0, O_RUN,   "race_stay");
        push_exp(2, 0, O_RUN,   "race_drain");
        push_exp(3, 0, O_SLEEP, "race_sleep");
        tick(1);
        wake_i = 1'b0;
        tick(2);
        sleep_req_i = 1'b0;
        wake_i = 1'b1;
        push_exp(3, 0, O_WAKEP, "race_wake_pulse");
        tick(1);
        wake_i = 1'b0;
        tick(3);

        // wake on DRAIN cycle 3 with busy low: wake wins, no sleep, no pulses
        sleep_req_i = 1'b1;
        core_busy_i = 1'b1;
        for (int k = 1; k <= 3; k++) push_exp(k, 0, O_RUN, "abort_drain");
        tick(3);
        sleep_req_i = 1'b0;
        core_busy_i = 1'b0;
        wake_i = 1'b1;
        for (int k = 1; k <= 4; k++) push_exp(k, 0, O_RUN, "abort_awake");
        tick(1);
        wake_i = 1'b0;
        tick(4);

        // reset while in SLEEP
        sleep_req_i = 1'b1;
        push_exp(2, 0, O_SLEEP, "pre_reset_sleep");
        tick(2);
        rst_i = 1'b1;
        sleep_req_i = 1'b0;
        push_exp(1, 0, O_RUN, "rst_in_sleep");
        push_exp(2, 0, O_RUN, "rst_in_sleep2");
        push_exp(3, 0, O_RUN, "rst_no_wake");
        tick(2);
        rst_i = 1'b0;
        tick(1);

        // DRAIN_TIMEOUT=1 / WAKE_SETTLE=1 corner
        sleep_req_i = 1'b1;
        core_busy_i = 1'b1;
        push_exp(1, 1, O_RUN, "c_drain");
        push_exp(2, 1, O_TOP, "c_timeout");
        push_exp(3, 1, O_RUN, "c_timeout_once");
        tick(2);
        sleep_req_i = 1'b0;
        core_busy_i = 1'b0;
        tick(1);
        sleep_req_i = 1'b1;
        push_exp(2, 1, O_SLEEP, "c_sleep");
        tick(2);
        sleep_req_i = 1'b0;
        wake_i = 1'b1;
        push_exp(1, 1, O_RUN,   "c_wake");
        push_exp(2, 1, O_WAKEP, "c_wake_pulse");
        push_exp(3, 1, O_RUN,   "c_after_wake");
        tick(1);
        wake_i = 1'b0;
        tick(3);

        rst_i = 1'b1;
        tick(2);
        rst_i = 1'b0;

`ifdef CV32E40S_SLEEP_STATS_EN
        // 100 cycles in SLEEP
        sleep_req_i = 1'b1;
        tick(2);
        sleep_req_i = 1'b0;
        tick(99);
        wake_i = 1'b1;
        push_exp_st(1, O_RUN,   32'd100, "stats_100");
        push_exp_st(3, O_WAKEP, 32'd100, "stats_hold");
        tick(1);
        wake_i = 1'b0;
        tick(3);
        // saturation near the top of the range
        sleep_req_i = 1'b1;
        tick(2);
        sleep_req_i = 1'b0;
        force u_dut0.sleep_cycles_q = 32'hFFFF_FFFD;
        #1;
        release u_dut0.sleep_cycles_q;
        push_exp_st(1, O_SLEEP, 32'hFFFF_FFFE, "stats_near");
        push_exp_st(2, O_SLEEP, 32'hFFFF_FFFF, "stats_max");
        push_exp_st(4, O_SLEEP, 32'hFFFF_FFFF, "stats_sat");
        tick(4);
        wake_i = 1'b1;
        push_exp_st(1, O_RUN, 32'hFFFF_FFFF, "stats_sat_wake");
        tick(1);
        wake_i = 1'b0;
        tick(3);
`endif

        tick(2);
        n_tests++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending entries want 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
